datapath_controller: RTL and testbench

//  Multi-cycle FSM sequencer for the 16-bit CPU datapath.
//  - Holds the instruction register (IR) and drives the PC.
//  - Drives every control input of the data memory, register file, write-back mux and ALU.
//  - Fetches one instruction, decodes it and runs 1..N execute cycles.
//  - Sits between instruction memory/PC and the data memory + register file datapath.

---
 rtl/datapath_ctrl_pkg.sv | 35 +++
 rtl/datapath_controller_if.sv | 34 +++
 rtl/datapath_controller.sv | 129 ++++++++++++
 tb/tb_datapath_controller.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared opcode, FSM state and control-field encodings for the datapath controller.
package datapath_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5,
    OP_LOADC = 4'h6
  } opcode_e;

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    LOAD_A = 4'd3,
    LOAD_B = 4'd4,
    STORE  = 4'd5,
    ADD    = 4'd6,
    SUB    = 4'd7,
    HALT   = 4'd8,
    LOADC  = 4'd9
  } state_e;

  localparam logic [1:0] RF_S_ALU = 2'b00;
  localparam logic [1:0] RF_S_MEM = 2'b01;
  localparam logic [1:0] RF_S_IR  = 2'b10;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/datapath_controller_if.sv
// Instruction input and datapath control bundle between the sequencer (master) and datapath (slave).
interface datapath_controller_if #(
  parameter int IW  = 16,
  parameter int DAW = 8,
  parameter int RAW = 4
);
  logic [IW-1:0]  instr;
  logic           PC_clr;
  logic           PC_up;
  logic           IR_ld;
  logic [DAW-1:0] D_addr;
  logic           D_W_en;
  logic [1:0]     RF_s;
  logic [RAW-1:0] RF_W_addr;
  logic           RF_W_en;
  logic [RAW-1:0] RF_Ra_addr;
  logic [RAW-1:0] RF_Rb_addr;
  logic [2:0]     ALU_s0;
  logic           halted;
  logic [3:0]     state;
  logic [15:0]    retired;

  modport master (
    input  instr,
    output PC_clr, PC_up, IR_ld, D_addr, D_W_en, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, halted, state, retired
  );

  modport slave (
    output instr,
    input  PC_clr, PC_up, IR_ld, D_addr, D_W_en, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, halted, state, retired
  );
endinterface

// File: rtl/datapath_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit CPU datapath; outputs decode from state+IR only.
// DATAPATH_CTRL_LOADC_EN adds the LOADC (load IR constant) instruction.
module datapath_controller
  import datapath_ctrl_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  datapath_controller_if.master bus
);

  localparam int WCW = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_RD_LAT - 1);

  state_e         state_q, state_d;
  logic [15:0]    ir;
  logic [WCW-1:0] wait_cnt;
  logic [15:0]    retired_q;
  logic           retire;
  logic           wait_last;

  assign wait_last = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT;
      ir        <= '0;
      wait_cnt  <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH) ir <= bus.instr;
      if (state_q == LOAD_A) wait_cnt <= wait_last ? '0 : wait_cnt + 1'b1;
      if (retire) retired_q <= retired_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      INIT:  state_d = FETCH;
      FETCH: state_d = DECODE;
      DECODE: begin
        case (ir[15:12])
          OP_STORE: state_d = STORE;
          OP_LOAD:  state_d = LOAD_A;
          OP_ADD:   state_d = ADD;
          OP_SUB:   state_d = SUB;
          OP_HALT:  state_d = HALT;
`ifdef DATAPATH_CTRL_LOADC_EN
          OP_LOADC: state_d = LOADC;
`endif
          // NOOP and any unassigned opcode retire straight from decode
          default: begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        endcase
      end
      LOAD_A: if (wait_last) state_d = LOAD_B;
`ifdef DATAPATH_CTRL_LOADC_EN
      LOADC,
`endif
      LOAD_B, STORE, ADD, SUB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      HALT:    state_d = HALT;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    bus.PC_clr     = 1'b0;
    bus.PC_up      = 1'b0;
    bus.IR_ld      = 1'b0;
    bus.D_addr     = '0;
    bus.D_W_en     = 1'b0;
    bus.RF_s       = RF_S_ALU;
    bus.RF_W_addr  = '0;
    bus.RF_W_en    = 1'b0;
    bus.RF_Ra_addr = '0;
    bus.RF_Rb_addr = '0;
    bus.ALU_s0     = ALU_PASS;
    bus.halted     = 1'b0;
    case (state_q)
      INIT: bus.PC_clr = 1'b1;
      FETCH: begin
        bus.PC_up = 1'b1;
        bus.IR_ld = 1'b1;
      end
      LOAD_A: bus.D_addr = ir[7:0];
      LOAD_B: begin
        bus.D_addr    = ir[7:0];
        bus.RF_s      = RF_S_MEM;
        bus.RF_W_addr = ir[11:8];
        bus.RF_W_en   = 1'b1;
      end
      STORE: begin
        bus.D_addr     = ir[11:4];
        bus.RF_Ra_addr = ir[3:0];
        bus.D_W_en     = 1'b1;
      end
      ADD, SUB: begin
        bus.RF_Ra_addr = ir[11:8];
        bus.RF_Rb_addr = ir[7:4];
        bus.RF_W_addr  = ir[3:0];
        bus.RF_s       = RF_S_ALU;
        bus.ALU_s0     = (state_q == ADD) ? ALU_ADD : ALU_SUB;
        bus.RF_W_en    = 1'b1;
      end
`ifdef DATAPATH_CTRL_LOADC_EN
      LOADC: begin
        bus.RF_s      = RF_S_IR;
        bus.RF_W_addr = ir[11:8];
        bus.RF_W_en   = 1'b1;
      end
`endif
      HALT:    bus.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.state   = state_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_datapath_controller.sv
// Directed-vector bench for datapath_controller; expectations are hand-computed per instruction.
module tb_datapath_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  datapath_controller_if #(.IW(16), .DAW(8), .RAW(4)) bus ();

  datapath_controller #(.MEM_RD_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    bus.instr = 16'h0000;
    tick();
    tick();
    check_eq("rst_state", 32'(bus.state), 32'd0);
    check_eq("rst_pc_clr", 32'(bus.PC_clr), 32'd1);
    check_eq("rst_retired", 32'(bus.retired), 32'd0);
    check_eq("rst_rf_w_en", 32'(bus.RF_W_en), 32'd0);

    reset = 1'b0;
    tick();
    check_eq("fetch_state", 32'(bus.state), 32'd1);
    check_eq("fetch_pc_up", 32'(bus.PC_up), 32'd1);
    check_eq("fetch_ir_ld", 32'(bus.IR_ld), 32'd1);
    check_eq("fetch_pc_clr", 32'(bus.PC_clr), 32'd0);

    // LOAD R3, mem[1B]
    bus.instr = 16'h231B;
    tick();
    check_eq("ld_decode", 32'(bus.state), 32'd2);
    check_eq("ld_decode_wen", 32'({bus.RF_W_en, bus.D_W_en}), 32'd0);
    bus.instr = 16'hFFFF;  // IR must not follow instr after FETCH
    tick();
    check_eq("ld_a_state", 32'(bus.state), 32'd3);
    check_eq("ld_a_daddr", 32'(bus.D_addr), 32'h1B);
    check_eq("ld_a_wen", 32'(bus.RF_W_en), 32'd0);
    tick();
    check_eq("ld_b_state", 32'(bus.state), 32'd4);
    check_eq("ld_b_wen", 32'(bus.RF_W_en), 32'd1);
    check_eq("ld_b_waddr", 32'(bus.RF_W_addr), 32'd3);
    check_eq("ld_b_rfs", 32'(bus.RF_s), 32'd1);
    check_eq("ld_b_daddr", 32'(bus.D_addr), 32'h1B);
    tick();
    check_eq("ld_done_state", 32'(bus.state), 32'd1);
    check_eq("ld_retired", 32'(bus.retired), 32'd1);
    check_eq("ld_done_wen", 32'(bus.RF_W_en), 32'd0);

    // STORE mem[A5] <= R2
    bus.instr = 16'h1A52;
    tick();
    tick();
    check_eq("st_state", 32'(bus.state), 32'd5);
    check_eq("st_dwen", 32'(bus.D_W_en), 32'd1);
    check_eq("st_daddr", 32'(bus.D_addr), 32'hA5);
    check_eq("st_ra", 32'(bus.RF_Ra_addr), 32'd2);
    check_eq("st_rfwen", 32'(bus.RF_W_en), 32'd0);
    tick();
    check_eq("st_done_dwen", 32'(bus.D_W_en), 32'd0);
    check_eq("st_retired", 32'(bus.retired), 32'd2);

    // SUB R7 = R1 - R2
    bus.instr = 16'h4127;
    tick();
    tick();
    check_eq("sub_state", 32'(bus.state), 32'd7);
    check_eq("sub_ra", 32'(bus.RF_Ra_addr), 32'd1);
    check_eq("sub_rb", 32'(bus.RF_Rb_addr), 32'd2);
    check_eq("sub_wa", 32'(bus.RF_W_addr), 32'd7);
    check_eq("sub_alu", 32'(bus.ALU_s0), 32'b010);
    check_eq("sub_wen", 32'(bus.RF_W_en), 32'd1);
    check_eq("sub_rfs", 32'(bus.RF_s), 32'd0);
    tick();
    check_eq("sub_retired", 32'(bus.retired), 32'd3);

    // ADD R6 = R4 + R5
    bus.instr = 16'h3456;
    tick();
    tick();
    check_eq("add_state", 32'(bus.state), 32'd6);
    check_eq("add_ra", 32'(bus.RF_Ra_addr), 32'd4);
    check_eq("add_rb", 32'(bus.RF_Rb_addr), 32'd5);
    check_eq("add_wa", 32'(bus.RF_W_addr), 32'd6);
    check_eq("add_alu", 32'(bus.ALU_s0), 32'b001);
    check_eq("add_wen", 32'(bus.RF_W_en), 32'd1);
    tick();
    check_eq("add_retired", 32'(bus.retired), 32'd4);

    // NOOP retires from decode
    bus.instr = 16'h0000;
    tick();
    tick();
    check_eq("noop_state", 32'(bus.state), 32'd1);
    check_eq("noop_retired", 32'(bus.retired), 32'd5);

    // opcode 0110: LOADC when enabled, otherwise a NOOP
    bus.instr = 16'h64C8;
    tick();
    tick();
`ifdef DATAPATH_CTRL_LOADC_EN
    check_eq("ldc_state", 32'(bus.state), 32'd9);
    check_eq("ldc_rfs", 32'(bus.RF_s), 32'd2);
    check_eq("ldc_wa", 32'(bus.RF_W_addr), 32'd4);
    check_eq("ldc_wen", 32'(bus.RF_W_en), 32'd1);
    tick();
`else
    check_eq("op6_state", 32'(bus.state), 32'd1);
    check_eq("op6_wen", 32'({bus.RF_W_en, bus.D_W_en}), 32'd0);
    check_eq("op6_rfs", 32'(bus.RF_s), 32'd0);
`endif
    check_eq("op6_retired", 32'(bus.retired), 32'd6);

    // undefined opcode behaves as NOOP
    bus.instr = 16'hF123;
    tick();
    tick();
    check_eq("undef_state", 32'(bus.state), 32'd1);
    check_eq("undef_wen", 32'({bus.RF_W_en, bus.D_W_en}), 32'd0);
    check_eq("undef_retired", 32'(bus.retired), 32'd7);

    // reset during LOAD_A drops the pending register write
    bus.instr = 16'h2A40;
    tick();
    tick();
    check_eq("rst_ld_a_state", 32'(bus.state), 32'd3);
    reset = 1'b1;
    tick();
    check_eq("rst_ld_init", 32'(bus.state), 32'd0);
    check_eq("rst_ld_wen", 32'(bus.RF_W_en), 32'd0);
    check_eq("rst_ld_retired", 32'(bus.retired), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("rst_ld_fetch", 32'(bus.state), 32'd1);

    // HALT holds until reset
    bus.instr = 16'h5000;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      check_eq("halt_halted", 32'(bus.halted), 32'd1);
      check_eq("halt_pc_up", 32'({bus.PC_up, bus.IR_ld, bus.RF_W_en, bus.D_W_en}), 32'd0);
      tick();
    end
    check_eq("halt_state", 32'(bus.state), 32'd8);
    check_eq("halt_retired", 32'(bus.retired), 32'd0);
    reset = 1'b1;
    tick();
    check_eq("halt_rst_state", 32'(bus.state), 32'd0);
    check_eq("halt_rst_halted", 32'(bus.halted), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
